// File: rtl/jackpot_rotator.sv
`default_nettype none
// ============================================================================
// Module   : jackpot_rotator
// Brief    : Reaction game. A single lit LED rotates across WIDTH positions
//            (up, down, ping-pong or hold). A rising edge on the trigger
//            switch matching the lit LED wins; other edges count as misses.
// Revision : 1.0  initial release
// ============================================================================
module jackpot_rotator #(
    parameter int WIDTH    = 4,
    parameter int STEP_DIV = 1,
    parameter int MISS_W   = 4
) (
    input  logic              slowClock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  trigger,
    input  logic [1:0]        mode,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              won,
    output logic [MISS_W-1:0] miss_count
);

    // Step counter needs at least one bit even when every tick advances.
    localparam int                  c_STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_DIV - 1);
    localparam logic [WIDTH-1:0]    c_POS_HOME  = WIDTH'(1);

    localparam logic [1:0] c_MODE_UP   = 2'b00;
    localparam logic [1:0] c_MODE_DOWN = 2'b01;
    localparam logic [1:0] c_MODE_PONG = 2'b10;
    localparam logic [1:0] c_MODE_HOLD = 2'b11;

    typedef enum logic [0:0] {
        S_RUN = 1'b0,
        S_WIN = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_pos;
    logic [WIDTH-1:0]    w_pos_nxt;
    logic [WIDTH-1:0]    w_pos_moved;
    logic [WIDTH-1:0]    r_prev_trig;
    logic [WIDTH-1:0]    w_rise;
    logic [c_STEP_W-1:0] r_step;
    logic [c_STEP_W-1:0] w_step_nxt;
    logic                r_dir_up;
    logic                w_dir_up_nxt;
    logic                w_dir_moved;
    logic [MISS_W-1:0]   r_miss;
    logic [MISS_W-1:0]   w_miss_nxt;
    logic                w_hit;

    // Only fresh switch-on events matter; switches already held are ignored.
    assign w_rise = trigger & ~r_prev_trig;

    // A hit needs exactly one edge, on the LED the player is looking at now.
    assign w_hit = (w_rise == r_pos);

    // Candidate position/direction if this cycle is an advance cycle.
    always_comb begin
        w_pos_moved = r_pos;
        w_dir_moved = r_dir_up;
        case (mode)
            c_MODE_UP: begin
                w_pos_moved = {r_pos[WIDTH-2:0], r_pos[WIDTH-1]};
            end
            c_MODE_DOWN: begin
                w_pos_moved = {r_pos[0], r_pos[WIDTH-1:1]};
            end
            c_MODE_PONG: begin
                // Turn around at the ends so neither end LED is shown twice.
                if (r_dir_up) begin
                    if (r_pos[WIDTH-1]) begin
                        w_dir_moved = 1'b0;
                        w_pos_moved = r_pos >> 1;
                    end else begin
                        w_pos_moved = r_pos << 1;
                    end
                end else begin
                    if (r_pos[0]) begin
                        w_dir_moved = 1'b1;
                        w_pos_moved = r_pos << 1;
                    end else begin
                        w_pos_moved = r_pos >> 1;
                    end
                end
            end
            default: begin
                w_pos_moved = r_pos;
                w_dir_moved = r_dir_up;
            end
        endcase
    end

    // Game state machine: clear beats hit, hit beats miss/advance.
    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_step_nxt   = r_step;
        w_dir_up_nxt = r_dir_up;
        w_miss_nxt   = r_miss;
        case (r_state)
            S_RUN: begin
                if (clear) begin
                    w_pos_nxt    = c_POS_HOME;
                    w_step_nxt   = '0;
                    w_dir_up_nxt = 1'b1;
                    w_miss_nxt   = '0;
                end else if (w_hit) begin
                    // Freeze rotation; the LED bank shows all ones from now on.
                    w_state_nxt = S_WIN;
                end else begin
                    if ((w_rise != '0) && (r_miss != '1)) begin
                        w_miss_nxt = r_miss + 1'b1;
                    end
                    if (mode != c_MODE_HOLD) begin
                        if (r_step == c_STEP_LAST) begin
                            w_step_nxt   = '0;
                            w_pos_nxt    = w_pos_moved;
                            w_dir_up_nxt = w_dir_moved;
                        end else begin
                            w_step_nxt = r_step + 1'b1;
                        end
                    end
                end
            end
            S_WIN: begin
                // Edges are ignored here; only clear restarts the game.
                if (clear) begin
                    w_state_nxt  = S_RUN;
                    w_pos_nxt    = c_POS_HOME;
                    w_step_nxt   = '0;
                    w_dir_up_nxt = 1'b1;
                    w_miss_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // State registers plus registered LED/won outputs (no trigger-to-out path).
    always_ff @(posedge slowClock or posedge reset) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_pos       <= c_POS_HOME;
            r_step      <= '0;
            r_dir_up    <= 1'b1;
            r_miss      <= '0;
            r_prev_trig <= '1;
            out         <= c_POS_HOME;
            won         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_step      <= w_step_nxt;
            r_dir_up    <= w_dir_up_nxt;
            r_miss      <= w_miss_nxt;
            r_prev_trig <= trigger;
            out         <= (w_state_nxt == S_WIN) ? '1 : w_pos_nxt;
            won         <= (w_state_nxt == S_WIN);
        end
    end

    assign miss_count = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_jackpot_rotator.sv
`default_nettype none
// ============================================================================
// Module   : tb_jackpot_rotator
// Brief    : Bench for jackpot_rotator. Two instances (STEP_DIV 1 and 3)
//            share stimulus; an index-based game model predicts both.
// Revision : 1.0  initial release
// ============================================================================
module tb_jackpot_rotator;

    localparam int W  = 4;
    localparam int MW = 4;

    logic          slowClock = 1'b0;
    logic          reset     = 1'b1;
    logic [W-1:0]  trigger   = '1;
    logic [1:0]    mode      = 2'b00;
    logic          clear     = 1'b0;
    logic [W-1:0]  out0, out1;
    logic          won0, won1;
    logic [MW-1:0] miss0, miss1;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] seq1 [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                               4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [W-1:0] seq4 [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                               4'b0010, 4'b0001, 4'b0010};

    jackpot_rotator #(.WIDTH(W), .STEP_DIV(1), .MISS_W(MW)) u_dut_fast (
        .slowClock  (slowClock),
        .reset      (reset),
        .trigger    (trigger),
        .mode       (mode),
        .clear      (clear),
        .out        (out0),
        .won        (won0),
        .miss_count (miss0)
    );

    jackpot_rotator #(.WIDTH(W), .STEP_DIV(3), .MISS_W(MW)) u_dut_slow (
        .slowClock  (slowClock),
        .reset      (reset),
        .trigger    (trigger),
        .mode       (mode),
        .clear      (clear),
        .out        (out1),
        .won        (won1),
        .miss_count (miss1)
    );

    always #5 slowClock = ~slowClock;

    // ---------------- behavioural game model (index based) ----------------
    int           m_idx    [2];
    bit           m_dir_up [2];
    int           m_cnt    [2];
    bit           m_win    [2];
    int           m_miss   [2];
    logic [W-1:0] m_prev;

    function automatic int m_div(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [W-1:0] m_out(input int k);
        if (m_win[k]) return '1;
        return W'(1) << m_idx[k];
    endfunction

    task automatic m_restart(input int k);
        m_idx[k]    = 0;
        m_dir_up[k] = 1'b1;
        m_cnt[k]    = 0;
        m_win[k]    = 1'b0;
        m_miss[k]   = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) m_restart(k);
        m_prev = '1;
    endtask

    task automatic model_step(input logic [W-1:0] trig, input logic [1:0] md, input logic clr);
        logic [W-1:0] rise;
        rise = trig & ~m_prev;
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_restart(k);
            end else if (!m_win[k]) begin
                if (rise == m_out(k)) begin
                    m_win[k] = 1'b1;
                end else begin
                    if (rise != '0 && m_miss[k] < (1 << MW) - 1) m_miss[k]++;
                    if (md != 2'b11) begin
                        if (m_cnt[k] == m_div(k) - 1) begin
                            m_cnt[k] = 0;
                            case (md)
                                2'b00: m_idx[k] = (m_idx[k] + 1) % W;
                                2'b01: m_idx[k] = (m_idx[k] + W - 1) % W;
                                default: begin
                                    if (m_dir_up[k]) begin
                                        if (m_idx[k] == W - 1) begin
                                            m_dir_up[k] = 1'b0;
                                            m_idx[k]    = W - 2;
                                        end else m_idx[k]++;
                                    end else begin
                                        if (m_idx[k] == 0) begin
                                            m_dir_up[k] = 1'b1;
                                            m_idx[k]    = 1;
                                        end else m_idx[k]--;
                                    end
                                end
                            endcase
                        end else begin
                            m_cnt[k]++;
                        end
                    end
                end
            end
        end
        m_prev = trig;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model follows the asynchronous reset and each clock edge.
    always @(posedge reset) model_reset();
    always @(posedge slowClock) if (!reset) model_step(trigger, mode, clear);

    // Every cycle out of reset, both instances must match the model.
    always @(negedge slowClock) begin
        if (!reset) begin
            chk("cyc_out_fast",  32'(out0),  32'(m_out(0)));
            chk("cyc_won_fast",  32'(won0),  32'(m_win[0]));
            chk("cyc_miss_fast", 32'(miss0), 32'(m_miss[0]));
            chk("cyc_out_slow",  32'(out1),  32'(m_out(1)));
            chk("cyc_won_slow",  32'(won1),  32'(m_win[1]));
            chk("cyc_miss_slow", 32'(miss1), 32'(m_miss[1]));
        end
    end

    task automatic tick();
        @(negedge slowClock);
        #1;
    endtask

    task automatic wait_pos(input logic [W-1:0] p, input string name);
        int n;
        n = 0;
        while (out0 !== p && n < 16) begin
            tick();
            n++;
        end
        if (out0 !== p) begin
            checks++;
            failures++;
            $display("FAIL %s timeout out=%b required %b", name, out0, p);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge slowClock);
        #1 reset = 1'b0;

        // 1: held switches are not edges; plain rotation up
        chk("t1_rst_out",  32'(out0),  32'h1);
        chk("t1_rst_won",  32'(won0),  32'h0);
        chk("t1_rst_miss", 32'(miss0), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_out",  32'(out0),  32'(seq1[i]));
            chk("t1_miss", 32'(miss0), 32'h0);
        end

        // 2: hit on lit LED, edges ignored in WIN, clear restarts
        trigger = '0;
        wait_pos(4'b0100, "t2_wait");
        trigger = 4'b0100;
        tick();
        chk("t2_win_out", 32'(out0), 32'hF);
        chk("t2_win_won", 32'(won0), 32'h1);
        trigger = '0;      tick();
        trigger = 4'b1011; tick();
        trigger = '0;      tick();
        chk("t2_win_miss", 32'(miss0), 32'h0);
        chk("t2_win_hold", 32'(out0),  32'hF);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t2_clr_out", 32'(out0), 32'h1);
        chk("t2_clr_won", 32'(won0), 32'h0);

        // 3: wrong-bit miss, then ambiguous double edge miss
        wait_pos(4'b0001, "t3_wait_a");
        trigger = 4'b1000; tick();
        chk("t3_miss1", 32'(miss0), 32'h1);
        chk("t3_out1",  32'(out0),  32'h2);
        trigger = '0;
        wait_pos(4'b0001, "t3_wait_b");
        trigger = 4'b0011; tick();
        chk("t3_miss2", 32'(miss0), 32'h2);
        chk("t3_out2",  32'(out0),  32'h2);
        chk("t3_won",   32'(won0),  32'h0);
        trigger = '0;

        // 4: ping-pong from reset, then down from bit 0
        reset = 1'b1; mode = 2'b10; tick(); reset = 1'b0;
        chk("t4_rst_out", 32'(out0), 32'h1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t4_pong", 32'(out0), 32'(seq4[i]));
        end
        wait_pos(4'b0001, "t4_wait");
        mode = 2'b01; tick();
        chk("t4_down_wrap", 32'(out0), 32'h8);

        // 5: divider on slow instance, hold freezes, miss saturation
        reset = 1'b1; mode = 2'b00; tick(); reset = 1'b0;
        for (int t = 0; t < 7; t++) begin
            if (t > 0) tick();
            chk("t5_div", 32'(out1), 32'(4'b0001 << (t / 3)));
        end
        mode = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_slow", 32'(out1), 32'h4);
            chk("t5_hold_fast", 32'(out0), 32'h4);
        end
        for (int i = 0; i < 17; i++) begin
            trigger = 4'b0001; tick();
            trigger = '0;      tick();
            if (i == 13) chk("t5_miss14", 32'(miss0), 32'hE);
        end
        chk("t5_sat_fast", 32'(miss0), 32'hF);
        chk("t5_sat_slow", 32'(miss1), 32'hF);

        // 6: async reset mid-WIN and mid-step; clear beats a matching edge
        trigger = 4'b0100; tick();
        chk("t6_win", 32'(won0), 32'h1);
        @(posedge slowClock); #2 reset = 1'b1;
        #1;
        chk("t6_ar_out",  32'(out0),  32'h1);
        chk("t6_ar_won",  32'(won0),  32'h0);
        chk("t6_ar_miss", 32'(miss0), 32'h0);
        tick(); reset = 1'b0; mode = 2'b00; trigger = '0;
        tick();
        @(posedge slowClock); #2 reset = 1'b1;
        #1;
        chk("t6_step_out", 32'(out1),  32'h1);
        chk("t6_step_miss", 32'(miss1), 32'h0);
        tick(); reset = 1'b0;
        tick(); chk("t6_step_a", 32'(out1), 32'h1);
        tick(); chk("t6_step_b", 32'(out1), 32'h1);
        tick(); chk("t6_step_c", 32'(out1), 32'h2);
        wait_pos(4'b0001, "t6_wait");
        trigger = 4'b0001; clear = 1'b1; tick(); clear = 1'b0;
        chk("t6_clr_hit_out", 32'(out0), 32'h1);
        chk("t6_clr_hit_won", 32'(won0), 32'h0);

        // Random play against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) trigger = trigger ^ (W'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 29) == 0) trigger = W'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            clear = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1; tick(); reset = 1'b0;
            end
            tick();
        end
        clear = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
